sad_best_match: RTL and testbench

- Downstream of the 8-input row adder tree; consumes one row sum per handshake.
- Accumulates ROWS row sums into one block SAD per candidate position.
- Scans SEARCH_W x SEARCH_H candidates in raster order and keeps the minimum SAD and its candidate coordinates.
- Its result feeds the motion-vector output stage of the motion-estimation datapath.

---
 rtl/sad_best_match_pkg.sv | 14 +
 rtl/sad_row_accumulator.sv | 43 ++++
 rtl/sad_best_match.sv | 94 +++++++++
 tb/tb_sad_best_match.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sad_best_match_pkg.sv
// sad_best_match_pkg: shared state encoding and width helpers for the SAD search path
package sad_best_match_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_e;

    function automatic int sad_bits(input int elem_bits, input int rows);
        return elem_bits + $clog2(rows);
    endfunction

    function automatic int mv_bits(input int w, input int h);
        return $clog2(w > h ? w : h);
    endfunction

endpackage

// File: rtl/sad_row_accumulator.sv
// sad_row_accumulator: sums ROWS row sums into one block SAD and flags the last row
module sad_row_accumulator
    import sad_best_match_pkg::*;
#(
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int ROWS              = 8,
    parameter int SAD_BIT_DEPTH     = sad_bits(ELEMENT_BIT_DEPTH, ROWS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         accept_i,
    input  logic [ELEMENT_BIT_DEPTH-1:0] row_sum_i,
    output logic [SAD_BIT_DEPTH-1:0]     acc_o,
    output logic                         block_complete_o
);

    localparam int CW = $clog2(ROWS);

    logic [SAD_BIT_DEPTH-1:0] acc_q, acc_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    // Clear wins over accept; the two never coincide since accept only happens in ACCUM.
    always_comb begin
        acc_d = clr_i ? '0 : accept_i ? acc_q + SAD_BIT_DEPTH'(row_sum_i) : acc_q;
        cnt_d = clr_i ? '0 : accept_i ? cnt_q + CW'(1) : cnt_q;
    end

    // Accumulator and row counter state; ROWS is a power of two so the counter wraps on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o            = acc_q;
    assign block_complete_o = accept_i && (cnt_q == CW'(ROWS - 1));

endmodule

// File: rtl/sad_best_match.sv
// sad_best_match: raster scan of candidate block SADs, keeping the first minimum and its position
module sad_best_match
    import sad_best_match_pkg::*;
#(
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int ROWS              = 8,
    parameter int SEARCH_W          = 4,
    parameter int SEARCH_H          = 4,
    parameter int SAD_BIT_DEPTH     = sad_bits(ELEMENT_BIT_DEPTH, ROWS),
    parameter int MV_BITS           = mv_bits(SEARCH_W, SEARCH_H)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ELEMENT_BIT_DEPTH-1:0] row_sum,
    input  logic                         row_valid,
    output logic                         row_ready,
    output logic                         busy,
    output logic                         done,
    output logic [SAD_BIT_DEPTH-1:0]     best_sad,
    output logic [MV_BITS-1:0]           best_x,
    output logic [MV_BITS-1:0]           best_y
);

    localparam logic [MV_BITS-1:0] X_LAST = MV_BITS'(SEARCH_W - 1);
    localparam logic [MV_BITS-1:0] Y_LAST = MV_BITS'(SEARCH_H - 1);

    state_e                   state_q;
    logic [MV_BITS-1:0]       cand_x_q, cand_y_q, best_x_q, best_y_q;
    logic [SAD_BIT_DEPTH-1:0] best_sad_q, acc;
    logic                     accept, clr, block_complete, last_x, last_y;

    assign row_ready = state_q == ACCUM;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign accept    = row_valid && row_ready;
    assign clr       = (state_q == IDLE && start) || state_q == COMPARE;
    assign last_x    = cand_x_q == X_LAST;
    assign last_y    = cand_y_q == Y_LAST;

    sad_row_accumulator #(
        .ELEMENT_BIT_DEPTH(ELEMENT_BIT_DEPTH),
        .ROWS             (ROWS),
        .SAD_BIT_DEPTH    (SAD_BIT_DEPTH)
    ) u_acc (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr_i           (clr),
        .accept_i        (accept),
        .row_sum_i       (row_sum),
        .acc_o           (acc),
        .block_complete_o(block_complete)
    );

    // Search FSM with candidate scan and best-match tracking; strict less-than keeps the earliest tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            best_sad_q <= '1;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q    <= ACCUM;
                    cand_x_q   <= '0;
                    cand_y_q   <= '0;
                    best_sad_q <= '1;
                    best_x_q   <= '0;
                    best_y_q   <= '0;
                end
                ACCUM: if (block_complete) state_q <= COMPARE;
                COMPARE: begin
                    if (acc < best_sad_q) begin
                        best_sad_q <= acc;
                        best_x_q   <= cand_x_q;
                        best_y_q   <= cand_y_q;
                    end
                    cand_x_q <= last_x ? '0 : cand_x_q + MV_BITS'(1);
                    cand_y_q <= last_x ? (last_y ? '0 : cand_y_q + MV_BITS'(1)) : cand_y_q;
                    state_q  <= (last_x && last_y) ? DONE : ACCUM;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign best_sad = best_sad_q;
    assign best_x   = best_x_q;
    assign best_y   = best_y_q;

endmodule

// File: tb/tb_sad_best_match.sv
// tb_sad_best_match: directed table of search patterns plus reset and start-pulse sequences
module tb_sad_best_match;

    localparam int EB   = 14;
    localparam int ROWS = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int SB   = EB + 3;
    localparam int MB   = 2;
    localparam int ALL1 = 131071;

    typedef struct {
        int base;
        int sx;
        int sy;
        int sv;
        bit rnd;
        bit poke;
        int exp_sad;
        int exp_x;
        int exp_y;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, start, row_valid;
    logic [EB-1:0] row_sum;
    logic          row_ready, busy, done;
    logic [SB-1:0] best_sad;
    logic [MB-1:0] best_x, best_y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sad_best_match dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .row_sum  (row_sum),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .busy     (busy),
        .done     (done),
        .best_sad (best_sad),
        .best_x   (best_x),
        .best_y   (best_y)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_idle_reset(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_ready"}, row_ready, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_sad"}, best_sad, ALL1);
        check({nm, "_x"}, best_x, 0);
        check({nm, "_y"}, best_y, 0);
    endtask

    // Runs one full search from the current negedge; returns at the negedge after DONE.
    task automatic run(input vec_t v);
        int  cand = 0, rows = 0, cyc = 0, budget = 0;
        bit  seen_done = 0, cmp_next = 0, acc_now;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && budget < 4000) begin
            if (row_ready || cyc > 0) cyc++;
            if (cmp_next) begin
                check("ready_in_compare", row_ready, 0);
                check("busy_in_compare", busy, 1);
                cmp_next = 0;
            end
            if (done) begin
                seen_done = 1;
            end else begin
                row_valid = 1'b0;
                if (row_ready) begin
                    row_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    row_sum   = EB'((cand % W == v.sx && cand / W == v.sy) ? v.sv : v.base);
                end
                start   = v.poke && cand == 1 && rows == 2;
                acc_now = row_valid && row_ready;
                @(posedge clk);
                if (acc_now) begin
                    rows++;
                    if (rows == ROWS) begin
                        rows = 0;
                        cand++;
                        cmp_next = 1;
                    end
                end
                @(negedge clk);
                budget++;
            end
        end
        row_valid = 1'b0;
        start     = v.poke;
        check("done_seen", seen_done, 1);
        check("blocks_before_done", cand, W * H);
        if (!v.rnd) check("latency", cyc, W * H * (ROWS + 1) + 1);
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("best_sad", best_sad, v.exp_sad);
        check("best_x", best_x, v.exp_x);
        check("best_y", best_y, v.exp_y);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1,     2, 1, 0,     1'b0, 1'b0, 0,      2, 1};
        tbl[1] = '{16383, 3, 3, 16382, 1'b0, 1'b0, 131056, 3, 3};
        tbl[2] = '{5,     0, 0, 5,     1'b0, 1'b0, 40,     0, 0};
        tbl[3] = '{1,     2, 1, 0,     1'b1, 1'b0, 0,      2, 1};
        tbl[4] = '{2,     0, 0, 9,     1'b0, 1'b0, 16,     1, 0};
        tbl[5] = '{3,     1, 3, 2,     1'b0, 1'b1, 16,     1, 3};

        rst_n     = 1'b0;
        start     = 1'b0;
        row_valid = 1'b0;
        row_sum   = '0;
        repeat (2) @(negedge clk);
        check_idle_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run(tbl[i]);

        // Start one cycle after DONE must begin a fresh search with best values cleared.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fresh_busy", busy, 1);
        check("fresh_ready", row_ready, 1);
        check("fresh_sad", best_sad, ALL1);
        check("fresh_x", best_x, 0);
        check("fresh_y", best_y, 0);

        // Abort with reset after three accepted rows.
        row_sum   = EB'(7);
        row_valid = 1'b1;
        repeat (3) @(negedge clk);
        row_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check_idle_reset("abort");
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", done, 0);

        // A completed result must be wiped by reset while idle.
        run(tbl[0]);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_reset("idle_reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
